mem_arbiter: RTL

Two-port arbiter sharing the single downstream memory bus between instruction fetch (ibus) and the memory stage (dbus, which also carries page-table-walk reads). Sits between the pipeline core and the cache/bus interface. Latches one request at a time, holds it on the shared bus until the downstream data_ok, then routes the response to the owner.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory bus between instruction fetch
// (ibus) and the memory stage (dbus). One request is latched at a time and
// held on the shared bus until the downstream data_ok. The response is then
// routed back to the port that owns the transaction.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking;
// without it the memory stage always wins a tie.

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  oreq,
  input  dbus_resp_t oresp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t    r_state;
  state_t    w_nextState;
  dbus_req_t r_req;
  dbus_req_t w_nextReq;
  logic      r_last;
  logic      w_nextLast;
  logic      w_grantI;
  logic      w_grantD;
  logic      w_unusedAddrOk;

  // The downstream address handshake is implied by data_ok on this bus.
  assign w_unusedAddrOk = oresp.addr_ok;

  // State, latched request and last-granted port; reset is async active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_req   <= w_nextReq;
      r_last  <= w_nextLast;
    end
  end

  // Grant selection in IDLE and completion detection while busy.
  always_comb begin
    w_nextState = r_state;
    w_nextReq   = r_req;
    w_nextLast  = r_last;
    w_grantI    = 1'b0;
    w_grantD    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (dreq.valid && ireq.valid) begin
`ifdef MEM_ARB_RR_EN
          w_grantD = ~r_last;
          w_grantI = r_last;
`else
          w_grantD = 1'b1;
`endif
        end else begin
          w_grantD = dreq.valid;
          w_grantI = ireq.valid;
        end
        if (w_grantD) begin
          w_nextState     = BUSY_D;
          w_nextReq       = dreq;
          w_nextReq.valid = 1'b1;
          w_nextLast      = 1'b1;
        end else if (w_grantI) begin
          w_nextState      = BUSY_I;
          w_nextReq.valid  = 1'b1;
          w_nextReq.addr   = ireq.addr;
          w_nextReq.size   = MSIZE4;
          w_nextReq.strobe = '0;
          w_nextReq.data   = '0;
          w_nextLast       = 1'b0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (oresp.data_ok) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // The shared bus carries the latched request; valid follows the busy state.
  always_comb begin
    oreq       = r_req;
    oreq.valid = (r_state != IDLE);
  end

  // Route the completing response to its owner; everything else reads zero.
  always_comb begin
    iresp = '0;
    dresp = '0;
    if (oresp.data_ok) begin
      if (r_state == BUSY_I) begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = r_req.addr[2] ? oresp.data[63:32] : oresp.data[31:0];
      end else if (r_state == BUSY_D) begin
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = oresp.data;
      end
    end
  end

endmodule
